// File: rtl/i2c_master_pkg.sv
// ----------------------------------------------------------------------------
// i2c_master_pkg
//   Shared definitions for the I2C master: CPU command codes, the command
//   FSM state encoding, the four-phase SCL bit-time encoding, and a small
//   helper to step through the phases.
// ----------------------------------------------------------------------------
package i2c_master_pkg;

    // Command code carried in data_in[10:8]; codes 6 and 7 behave as NOP.
    typedef enum logic [2:0] {
        CMD_NOP       = 3'd0,
        CMD_START     = 3'd1,
        CMD_WRITE     = 3'd2,
        CMD_READ_ACK  = 3'd3,
        CMD_READ_NACK = 3'd4,
        CMD_STOP      = 3'd5
    } cmd_e;

    // Command FSM states; DATA covers WRITE, READ_ACK and READ_NACK.
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } state_e;

    // One SCL bit time is four quarter-period phases.
    typedef enum logic [1:0] {
        PH_0,
        PH_1,
        PH_2,
        PH_3
    } phase_e;

    // Index of the acknowledge bit within a DATA command (bits 0..8).
    localparam logic [3:0] LAST_BIT = 4'd8;

    function automatic phase_e next_phase(input phase_e p);
        phase_e n;
        case (p)
            PH_0:    n = PH_1;
            PH_1:    n = PH_2;
            PH_2:    n = PH_3;
            default: n = PH_0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/i2c_master_qtick.sv
// ----------------------------------------------------------------------------
// i2c_qtick
//   Quarter-period tick generator. Produces a one-cycle tick on the last clk
//   cycle of every CLOCK_DIV-cycle quarter period.
//
//   clk      in   block clock (rising edge)
//   nreset   in   synchronous active-low reset
//   hold     in   freeze the counter (used for SCL clock stretching)
//   restart  in   begin a fresh quarter period on the next cycle
//   tick     out  high on the last cycle of each quarter period
// ----------------------------------------------------------------------------
module i2c_qtick #(
    parameter int CLOCK_DIV    = 25,
    parameter int COUNTER_BITS = 8
) (
    input  logic clk,
    input  logic nreset,
    input  logic hold,
    input  logic restart,
    output logic tick
);

    localparam logic [COUNTER_BITS-1:0] LAST = COUNTER_BITS'(CLOCK_DIV - 1);

    logic [COUNTER_BITS-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!nreset || restart) begin
            cnt_q <= '0;
        end else if (!hold) begin
            cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + COUNTER_BITS'(1);
        end
    end

    // A held counter must not tick, otherwise a stretched phase could end
    // while the counter sits on its last value.
    assign tick = (cnt_q == LAST) && !hold;

endmodule

// File: rtl/i2c_master.sv
// ----------------------------------------------------------------------------
// i2c_master
//   Byte-level I2C master driven by single CPU commands (START, WRITE,
//   READ_ACK, READ_NACK, STOP). Each SCL bit time is split into four phases
//   of CLOCK_DIV clk cycles; SCL clock stretching is honoured in phase 1.
//
//   clk        in   block clock (rising edge)
//   nreset     in   synchronous active-low reset
//   nwr        in   active-low command strobe; only its falling edge counts
//   data_in    in   [10:8] command code, [7:0] byte to write
//   data_out   out  byte received by the last READ command
//   busy       out  high while a command executes
//   nack       out  acknowledge sampled after the last WRITE (1 = NACK)
//   scl, sda   out  open-drain controls (1 = release, 0 = pull low)
//   scl_in     in   SCL line level (already synchronised)
//   sda_in     in   SDA line level (already synchronised)
// ----------------------------------------------------------------------------
module i2c_master
    import i2c_master_pkg::*;
#(
    parameter int CLOCK_DIV    = 25,
    parameter int COUNTER_BITS = 8
) (
    input  logic        clk,
    input  logic        nreset,
    input  logic        nwr,
    input  logic [10:0] data_in,
    output logic [7:0]  data_out,
    output logic        busy,
    output logic        nack,
    output logic        scl,
    output logic        sda,
    input  logic        scl_in,
    input  logic        sda_in
);

    state_e     state_q, state_n;
    phase_e     phase_q, phase_n;
    logic [3:0] bit_cnt_q, bit_cnt_n;

    cmd_e       cmd_q;
    logic [7:0] byte_q;
    logic [7:0] rx_q;
    logic       ack_q;
    logic       nwr_q;
    logic       scl_hold_q;
    logic       sda_hold_q;

    logic       cmd_valid;
    logic       accept;
    logic       qtick;
    logic       stretch_hold;
    logic       last_bit;
    logic       cmd_done;
    logic       sample_en;
    logic       finish_en;
    logic       tx_bit;
    logic       scl_drv;
    logic       sda_drv;

    // ------------------------------------------------------------------
    // Command acceptance: falling edge of nwr, block idle, non-NOP code.
    // ------------------------------------------------------------------
    assign cmd_valid = (data_in[10:8] != CMD_NOP) && (data_in[10:8] <= CMD_STOP);
    assign accept    = nwr_q && !nwr && (state_q == ST_IDLE) && cmd_valid;
    assign busy      = (state_q != ST_IDLE);

    assign last_bit  = (bit_cnt_q == LAST_BIT);
    assign cmd_done  = (state_q != ST_DATA) || last_bit;

    // Phase counter freezes while a slave keeps SCL low in phase 1.
    assign stretch_hold = (state_q != ST_IDLE) && (phase_q == PH_1) && scl_drv && !scl_in;

    i2c_qtick #(
        .CLOCK_DIV   (CLOCK_DIV),
        .COUNTER_BITS(COUNTER_BITS)
    ) u_qtick (
        .clk    (clk),
        .nreset (nreset),
        .hold   (stretch_hold),
        .restart(accept),
        .tick   (qtick)
    );

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!nreset) begin
            state_q   <= ST_IDLE;
            phase_q   <= PH_0;
            bit_cnt_q <= '0;
        end else begin
            state_q   <= state_n;
            phase_q   <= phase_n;
            bit_cnt_q <= bit_cnt_n;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state, phase and bit counter
    // ------------------------------------------------------------------
    always_comb begin
        state_n   = state_q;
        phase_n   = phase_q;
        bit_cnt_n = bit_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    phase_n   = PH_0;
                    bit_cnt_n = '0;
                    case (data_in[10:8])
                        CMD_START: state_n = ST_START;
                        CMD_STOP:  state_n = ST_STOP;
                        default:   state_n = ST_DATA;
                    endcase
                end
            end
            default: begin
                if (qtick) begin
                    if (phase_q == PH_3) begin
                        phase_n = PH_0;
                        if (cmd_done) begin
                            state_n   = ST_IDLE;
                            bit_cnt_n = '0;
                        end else begin
                            bit_cnt_n = bit_cnt_q + 4'd1;
                        end
                    end else begin
                        phase_n = next_phase(phase_q);
                    end
                end
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: line outputs
    // ------------------------------------------------------------------
    always_comb begin
        // Bits 0..7 carry the write byte MSB first (reads release SDA);
        // bit 8 is the acknowledge slot, driven low only for READ_ACK.
        if (bit_cnt_q[3]) begin
            tx_bit = (cmd_q != CMD_READ_ACK);
        end else if (cmd_q == CMD_WRITE) begin
            tx_bit = byte_q[3'd7 - bit_cnt_q[2:0]];
        end else begin
            tx_bit = 1'b1;
        end

        // Idle keeps whatever was driven last, so the bus stays owned.
        scl_drv = scl_hold_q;
        sda_drv = sda_hold_q;
        case (state_q)
            ST_START: begin
                case (phase_q)
                    PH_0:    begin scl_drv = 1'b0; sda_drv = 1'b1; end
                    PH_1:    begin scl_drv = 1'b1; sda_drv = 1'b1; end
                    PH_2:    begin scl_drv = 1'b1; sda_drv = 1'b0; end
                    default: begin scl_drv = 1'b0; sda_drv = 1'b0; end
                endcase
            end
            ST_STOP: begin
                case (phase_q)
                    PH_0:    begin scl_drv = 1'b0; sda_drv = 1'b0; end
                    PH_1:    begin scl_drv = 1'b1; sda_drv = 1'b0; end
                    default: begin scl_drv = 1'b1; sda_drv = 1'b1; end
                endcase
            end
            ST_DATA: begin
                scl_drv = (phase_q == PH_1) || (phase_q == PH_2);
                sda_drv = tx_bit;
            end
            default: ;
        endcase
    end

    assign scl = scl_drv;
    assign sda = sda_drv;

    // ------------------------------------------------------------------
    // Datapath: command latch, receive shifter, result registers
    // ------------------------------------------------------------------
    assign sample_en = (state_q == ST_DATA) && qtick && (phase_q == PH_2);
    assign finish_en = (state_q == ST_DATA) && qtick && (phase_q == PH_3) && last_bit;

    always_ff @(posedge clk) begin
        if (!nreset) begin
            nwr_q      <= 1'b1;
            scl_hold_q <= 1'b1;
            sda_hold_q <= 1'b1;
            cmd_q      <= CMD_NOP;
            byte_q     <= '0;
            rx_q       <= '0;
            ack_q      <= 1'b0;
            data_out   <= '0;
            nack       <= 1'b0;
        end else begin
            nwr_q      <= nwr;
            scl_hold_q <= scl_drv;
            sda_hold_q <= sda_drv;

            if (accept) begin
                cmd_q  <= cmd_e'(data_in[10:8]);
                byte_q <= data_in[7:0];
            end

            if (sample_en) begin
                if (last_bit) begin
                    ack_q <= sda_in;
                end else begin
                    rx_q <= {rx_q[6:0], sda_in};
                end
            end

            // Results are published together with the return to idle.
            if (finish_en) begin
                if (cmd_q == CMD_WRITE) begin
                    nack <= ack_q;
                end else begin
                    data_out <= rx_q;
                end
            end
        end
    end

endmodule
